// File: rtl/pwm_pkg.sv
// Shared PWM definitions: datapath width, ramp FSM states and the period-end helper.
package pwm_pkg;

    localparam int unsigned PWM_W = 16;

    typedef enum logic [0:0] {
        IDLE,
        RAMP
    } state_e;

    // Last phase value of a period; a zero period collapses to a one-cycle period.
    function automatic int unsigned pm1_of(input int unsigned period);
        return (period == 32'd0) ? 32'd0 : period - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_phase_tracker.sv
// Phase counter that mirrors the PWM core counter and flags the last cycle of each period.
module pwm_phase_tracker
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_W
) (
    input  logic             clk_div,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] period,
    output logic             boundary
);

    logic [WIDTH-1:0] pm1;
    logic [WIDTH-1:0] ph_q, ph_d;
    logic             wrap;

    // Wrap when the phase reaches the last cycle; also catches a phase left
    // above a freshly shrunk period.
    always_comb begin
        pm1      = WIDTH'(pm1_of(32'(period)));
        wrap     = (ph_q >= pm1);
        boundary = enable && wrap;
        ph_d     = ph_q;
        if (enable) begin
            ph_d = wrap ? '0 : ph_q + WIDTH'(1);
        end
    end

    // Phase register.
    always_ff @(posedge clk_div or posedge reset) begin
        if (reset) begin
            ph_q <= '0;
        end else begin
            ph_q <= ph_d;
        end
    end

endmodule

// File: rtl/pwm_shadow_ramp.sv
// Shadow-register front end for the PWM core: requests apply only at period
// boundaries, with an optional per-period duty slew toward the requested target.
module pwm_shadow_ramp
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_W
) (
    input  logic             clk_div,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] period_req,
    input  logic [WIDTH-1:0] duty_req,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] period_o,
    output logic [WIDTH-1:0] duty_o,
    output logic             boundary,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] sh_period_q, sh_period_d;
    logic [WIDTH-1:0] sh_duty_q, sh_duty_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] target_q, target_d;
    state_e           state_q, state_d;
    logic             done_q, done_d;

    logic             apply;
    logic             rising;
    logic [WIDTH:0]   diff;

    pwm_phase_tracker #(
        .WIDTH (WIDTH)
    ) u_tracker (
        .clk_div  (clk_div),
        .reset    (reset),
        .enable   (enable),
        .period   (period_q),
        .boundary (boundary)
    );

    assign apply = boundary && pend_q;

    // Distance to target at WIDTH+1 bits so neither direction can wrap.
    always_comb begin
        rising = (target_q >= duty_q);
        diff   = rising ? ({1'b0, target_q} - {1'b0, duty_q})
                        : ({1'b0, duty_q} - {1'b0, target_q});
    end

    // Shadow capture, boundary apply and ramp sequencing.
    always_comb begin
        sh_period_d = sh_period_q;
        sh_duty_d   = sh_duty_q;
        pend_d      = pend_q;
        period_d    = period_q;
        duty_d      = duty_q;
        target_d    = target_q;
        state_d     = state_q;
        done_d      = 1'b0;

        if (load) begin
            sh_period_d = period_req;
            sh_duty_d   = (duty_req > period_req) ? period_req : duty_req;
            pend_d      = 1'b1;
        end

        if (apply) begin
            // Apply uses the held shadow; a coincident load stays pending.
            period_d = sh_period_q;
            target_d = sh_duty_q;
            if (!load) begin
                pend_d = 1'b0;
            end
            if ((step == '0) || (sh_duty_q == duty_q)) begin
                duty_d  = sh_duty_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = RAMP;
            end
        end else if (boundary && (state_q == RAMP)) begin
            if (diff <= {1'b0, step}) begin
                duty_d  = target_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end else if (rising) begin
                duty_d = duty_q + step;
            end else begin
                duty_d = duty_q - step;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_div or posedge reset) begin
        if (reset) begin
            sh_period_q <= '0;
            sh_duty_q   <= '0;
            pend_q      <= 1'b0;
            period_q    <= '0;
            duty_q      <= '0;
            target_q    <= '0;
            state_q     <= IDLE;
            done_q      <= 1'b0;
        end else begin
            sh_period_q <= sh_period_d;
            sh_duty_q   <= sh_duty_d;
            pend_q      <= pend_d;
            period_q    <= period_d;
            duty_q      <= duty_d;
            target_q    <= target_d;
            state_q     <= state_d;
            done_q      <= done_d;
        end
    end

    assign period_o = period_q;
    assign duty_o   = duty_q;
    assign busy     = pend_q || (state_q == RAMP);
    assign done     = done_q;

endmodule
